// File: rtl/bf16_add_arb.sv
// bf16_add_arb: round-robin arbiter and two-stage sequencer that time-shares
// one purely combinational bf16 adder among N requesters. Stage 1 holds the
// granted operand pair driving the adder; stage 2 captures the adder result
// with the winner's ID and presents it on a single valid/ready response port.
module bf16_add_arb #(
    parameter int N   = 4,
    parameter int E   = 8,
    parameter int M   = 7,
    parameter int IDW = $clog2(N)
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic [N-1:0]           req_v_i,
    input  logic [N*(1+E+M)-1:0]   req_a_i,
    input  logic [N*(1+E+M)-1:0]   req_b_i,
    output logic [N-1:0]           req_rdy_o,
    output logic                   add_sa_o,
    output logic [E-1:0]           add_ea_o,
    output logic [M-1:0]           add_ma_o,
    output logic                   add_sb_o,
    output logic [E-1:0]           add_eb_o,
    output logic [M-1:0]           add_mb_o,
    input  logic                   add_s_i,
    input  logic [E-1:0]           add_e_i,
    input  logic [M-1:0]           add_m_i,
    output logic                   rsp_v_o,
    input  logic                   rsp_rdy_i,
    output logic [IDW-1:0]         rsp_id_o,
    output logic [1+E+M-1:0]       rsp_data_o,
    output logic                   busy_o
);

    localparam int W = 1 + E + M;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           vld_p1_q, vld_p1_d;
    logic [IDW-1:0] id_p1_q, id_p1_d;
    logic [W-1:0]   a_p1_q, a_p1_d;
    logic [W-1:0]   b_p1_q, b_p1_d;
    logic           vld_p2_q, vld_p2_d;
    logic [IDW-1:0] id_p2_q, id_p2_d;
    logic [W-1:0]   data_p2_q, data_p2_d;

    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   sel_a, sel_b;
    logic           s2_adv, s1_can, accept;

    // Round-robin pick: first valid at or above ptr, else first valid below it (wrap).
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < N; i++) begin
            if (!gnt_found && req_v_i[i] && (IDW'(i) >= ptr_q)) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(i);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!gnt_found && req_v_i[i]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(i);
            end
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_id == IDW'(i)) begin
                sel_a = req_a_i[i*W +: W];
                sel_b = req_b_i[i*W +: W];
            end
        end
    end

    // Pipeline advance and handshake; ready is forced low while reset is asserted.
    always_comb begin
        s2_adv    = ~vld_p2_q | rsp_rdy_i;
        s1_can    = ~vld_p1_q | s2_adv;
        accept    = gnt_found & s1_can & nreset;
        req_rdy_o = '0;
        for (int i = 0; i < N; i++) begin
            req_rdy_o[i] = accept & (gnt_id == IDW'(i));
        end
    end

    // Next-state for pointer and both pipeline stages.
    always_comb begin
        ptr_d     = ptr_q;
        vld_p1_d  = vld_p1_q;
        id_p1_d   = id_p1_q;
        a_p1_d    = a_p1_q;
        b_p1_d    = b_p1_q;
        vld_p2_d  = vld_p2_q;
        id_p2_d   = id_p2_q;
        data_p2_d = data_p2_q;
        if (accept) begin
            ptr_d   = (gnt_id == IDW'(N-1)) ? '0 : gnt_id + IDW'(1);
            id_p1_d = gnt_id;
            a_p1_d  = sel_a;
            b_p1_d  = sel_b;
        end
        if (s1_can) begin
            vld_p1_d = accept;
        end
        if (s2_adv) begin
            vld_p2_d  = vld_p1_q;
            id_p2_d   = id_p1_q;
            data_p2_d = {add_s_i, add_e_i, add_m_i};
        end
    end

    // State registers; reset clears everything so no response survives reset.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr_q     <= '0;
            // stage 1: operand register
            vld_p1_q  <= 1'b0;
            id_p1_q   <= '0;
            a_p1_q    <= '0;
            b_p1_q    <= '0;
            // stage 2: result register
            vld_p2_q  <= 1'b0;
            id_p2_q   <= '0;
            data_p2_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            // stage 1: operand register
            vld_p1_q  <= vld_p1_d;
            id_p1_q   <= id_p1_d;
            a_p1_q    <= a_p1_d;
            b_p1_q    <= b_p1_d;
            // stage 2: result register
            vld_p2_q  <= vld_p2_d;
            id_p2_q   <= id_p2_d;
            data_p2_q <= data_p2_d;
        end
    end

    // Adder sees zeros whenever stage 1 is empty.
    assign add_sa_o = vld_p1_q & a_p1_q[W-1];
    assign add_ea_o = vld_p1_q ? a_p1_q[W-2 -: E] : '0;
    assign add_ma_o = vld_p1_q ? a_p1_q[M-1:0]    : '0;
    assign add_sb_o = vld_p1_q & b_p1_q[W-1];
    assign add_eb_o = vld_p1_q ? b_p1_q[W-2 -: E] : '0;
    assign add_mb_o = vld_p1_q ? b_p1_q[M-1:0]    : '0;

    assign rsp_v_o    = vld_p2_q;
    assign rsp_id_o   = id_p2_q;
    assign rsp_data_o = data_p2_q;
    assign busy_o     = vld_p1_q | vld_p2_q;

endmodule

// File: tb/tb_bf16_add_arb.sv
// Testbench for bf16_add_arb: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction-level model.
module tb_bf16_add_arb;

    localparam int N   = 4;
    localparam int E   = 8;
    localparam int M   = 7;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             nreset;
    logic [N-1:0]     req_v_i;
    logic [N*W-1:0]   req_a_i, req_b_i;
    logic [N-1:0]     req_rdy_o;
    logic             add_sa_o, add_sb_o, add_s_i;
    logic [E-1:0]     add_ea_o, add_eb_o, add_e_i;
    logic [M-1:0]     add_ma_o, add_mb_o, add_m_i;
    logic             rsp_v_o, rsp_rdy_i;
    logic [IDW-1:0]   rsp_id_o;
    logic [W-1:0]     rsp_data_o;
    logic             busy_o;

    logic             mode;
    logic [W-1:0]     add_a, add_b;

    bf16_add_arb #(.N(N), .E(E), .M(M), .IDW(IDW)) dut (
        .clk(clk), .nreset(nreset),
        .req_v_i(req_v_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rdy_o(req_rdy_o),
        .add_sa_o(add_sa_o), .add_ea_o(add_ea_o), .add_ma_o(add_ma_o),
        .add_sb_o(add_sb_o), .add_eb_o(add_eb_o), .add_mb_o(add_mb_o),
        .add_s_i(add_s_i), .add_e_i(add_e_i), .add_m_i(add_m_i),
        .rsp_v_o(rsp_v_o), .rsp_rdy_i(rsp_rdy_i), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Stub adder: mode 0 returns {sa, ea, mb}, mode 1 returns a XOR b.
    assign add_a = {add_sa_o, add_ea_o, add_ma_o};
    assign add_b = {add_sb_o, add_eb_o, add_mb_o};
    assign {add_s_i, add_e_i, add_m_i} = mode ? (add_a ^ add_b) : {add_a[W-1:M], add_b[M-1:0]};

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           acc;
    } item_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           md;
        logic [W-1:0]   exp;
    } vec_t;

    item_t        q[$];
    int           mptr     = 0;
    int           edge_n   = 0;
    int           last_pop = 0;
    int           last_g   = -1;
    logic [W-1:0] opa[N];
    logic [W-1:0] opb[N];
    logic [N-1:0] last_rdy;
    logic [N-1:0] vcur;
    vec_t         tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic md);
        return md ? (a ^ b) : {a[W-1:M], b[M-1:0]};
    endfunction

    // A response is visible once it has had one edge in the operand stage and
    // its predecessor has left the result register.
    function automatic bit front_vis();
        if (q.size() == 0) return 1'b0;
        return (edge_n >= q[0].acc + 1) && (edge_n >= last_pop);
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input logic [N-1:0] v, input logic rr);
        logic [W-1:0]   ea, eb;
        logic [N-1:0]   er;
        logic [IDW-1:0] gi;
        bit             vis, acc, pop;
        int             g, idx;
        item_t          it;
        vis = front_vis();
        chk("rsp_v", 32'(rsp_v_o), 32'(vis));
        if (vis) begin
            chk("rsp_id", 32'(rsp_id_o), 32'(q[0].id));
            chk("rsp_data", 32'(rsp_data_o), 32'(q[0].res));
        end
        chk("busy", 32'(busy_o), 32'(q.size() > 0));
        ea = '0;
        eb = '0;
        if (q.size() == 2) begin
            ea = q[1].a;
            eb = q[1].b;
        end else if (q.size() == 1 && !vis) begin
            ea = q[0].a;
            eb = q[0].b;
        end
        chk("add_a", 32'(add_a), 32'(ea));
        chk("add_b", 32'(add_b), 32'(eb));
        req_v_i   = v;
        rsp_rdy_i = rr;
        for (int i = 0; i < N; i++) begin
            req_a_i[i*W +: W] = opa[i];
            req_b_i[i*W +: W] = opb[i];
        end
        #1;
        g = -1;
        for (int off = 0; off < N; off++) begin
            idx = (mptr + off) % N;
            if (g < 0 && v[idx[IDW-1:0]]) g = idx;
        end
        gi = g[IDW-1:0];
        er = '0;
        if (g >= 0 && (q.size() < 2 || rr)) er[gi] = 1'b1;
        last_rdy = req_rdy_o;
        chk("req_rdy", 32'(req_rdy_o), 32'(er));
        acc = (er != '0);
        pop = vis && rr;
        @(posedge clk);
        edge_n++;
        if (pop) begin
            void'(q.pop_front());
            last_pop = edge_n;
        end
        last_g = -1;
        if (acc) begin
            it.id  = g;
            it.a   = opa[gi];
            it.b   = opb[gi];
            it.res = ref_add(opa[gi], opb[gi], mode);
            it.acc = edge_n;
            q.push_back(it);
            mptr    = (g + 1) % N;
            last_g  = g;
            opa[gi] = W'($urandom);
            opb[gi] = W'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step('0, 1'b1);
    endtask

    task automatic rand_phase(input int cycles);
        logic rr;
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++)
                if (!vcur[i] && $urandom_range(0, 2) == 0) vcur[i] = 1'b1;
            rr = ($urandom_range(0, 3) != 0);
            step(vcur, rr);
            if (last_g >= 0) vcur[last_g[IDW-1:0]] = 1'b0;
        end
        for (int c = 0; c < 20 && vcur != '0; c++) begin
            step(vcur, 1'b1);
            if (last_g >= 0) vcur[last_g[IDW-1:0]] = 1'b0;
        end
        chk("rand_all_accepted", 32'(vcur), 32'(0));
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{id: 2'd0, a: 16'h3F80, b: 16'h4000, md: 1'b0, exp: 16'h3F80};
        tbl[1] = '{id: 2'd1, a: 16'hC1A5, b: 16'h007F, md: 1'b0, exp: 16'hC1FF};
        tbl[2] = '{id: 2'd2, a: 16'h1234, b: 16'hFFFF, md: 1'b1, exp: 16'hEDCB};
        tbl[3] = '{id: 2'd3, a: 16'hAAAA, b: 16'h5555, md: 1'b1, exp: 16'hFFFF};
        tbl[4] = '{id: 2'd3, a: 16'h8000, b: 16'h0001, md: 1'b0, exp: 16'h8001};

        for (int i = 0; i < N; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
        end
        vcur      = '0;
        mode      = 1'b0;
        nreset    = 1'b0;
        req_v_i   = '1;
        rsp_rdy_i = 1'b0;
        req_a_i   = '0;
        req_b_i   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", 32'(req_rdy_o), 32'(0));
        chk("rst_rsp_v", 32'(rsp_v_o), 32'(0));
        chk("rst_rsp_id", 32'(rsp_id_o), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data_o), 32'(0));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_add_a", 32'(add_a), 32'(0));
        chk("rst_add_b", 32'(add_b), 32'(0));
        req_v_i = '0;
        nreset  = 1'b1;

        // Single operations from the vector table, with pipeline timing
        for (int t = 0; t < 5; t++) begin
            logic [N-1:0] oh;
            oh   = 4'(1) << tbl[t].id;
            mode = tbl[t].md;
            opa[tbl[t].id] = tbl[t].a;
            opb[tbl[t].id] = tbl[t].b;
            step(oh, 1'b1);
            chk("tbl_rdy", 32'(last_rdy), 32'(oh));
            chk("tbl_add_a", 32'(add_a), 32'(tbl[t].a));
            chk("tbl_add_b", 32'(add_b), 32'(tbl[t].b));
            chk("tbl_rsp_v_early", 32'(rsp_v_o), 32'(0));
            step('0, 1'b1);
            chk("tbl_rsp_v", 32'(rsp_v_o), 32'(1));
            chk("tbl_rsp_id", 32'(rsp_id_o), 32'(tbl[t].id));
            chk("tbl_rsp_data", 32'(rsp_data_o), 32'(tbl[t].exp));
            chk("tbl_add_a_after", 32'(add_a), 32'(0));
            step('0, 1'b1);
            chk("tbl_rsp_v_done", 32'(rsp_v_o), 32'(0));
            chk("tbl_busy_done", 32'(busy_o), 32'(0));
        end

        // Backpressure: pointer is 0 here
        mode = 1'b1;
        step(4'b0111, 1'b0);
        chk("bp_rdy0", 32'(last_rdy), 32'(4'b0001));
        step(4'b0110, 1'b0);
        chk("bp_rdy1", 32'(last_rdy), 32'(4'b0010));
        step(4'b0100, 1'b0);
        chk("bp_stall_rdy", 32'(last_rdy), 32'(0));
        chk("bp_stall_busy", 32'(busy_o), 32'(1));
        step(4'b0100, 1'b0);
        chk("bp_stall_rdy2", 32'(last_rdy), 32'(0));
        chk("bp_rsp_id0", 32'(rsp_id_o), 32'(0));
        step(4'b0100, 1'b1);
        chk("bp_rdy2", 32'(last_rdy), 32'(4'b0100));
        chk("bp_rsp_id1", 32'(rsp_id_o), 32'(1));
        drain();

        // Wrap-around: last grant was 2, only requesters 1 and 3 valid
        step(4'b1010, 1'b1);
        chk("wrap_g3a", 32'(last_rdy), 32'(4'b1000));
        step(4'b1010, 1'b1);
        chk("wrap_g1", 32'(last_rdy), 32'(4'b0010));
        step(4'b1010, 1'b1);
        chk("wrap_g3b", 32'(last_rdy), 32'(4'b1000));
        drain();

        // Full-load fairness from pointer 0
        for (int j = 0; j < 8; j++) begin
            step(4'b1111, 1'b1);
            chk("fair_rdy", 32'(last_rdy), 32'(4'(1) << (j % 4)));
            if (j >= 1) begin
                chk("fair_rsp_v", 32'(rsp_v_o), 32'(1));
                chk("fair_rsp_id", 32'(rsp_id_o), 32'((j - 1) % 4));
            end
        end
        drain();

        // Randomized traffic under both stub modes
        mode = 1'b0;
        rand_phase(250);
        mode = 1'b1;
        rand_phase(250);

        // Reset with both stages full, dropped between edges
        mode = 1'b0;
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        chk("pre_rst_busy", 32'(busy_o), 32'(1));
        chk("pre_rst_rsp_v", 32'(rsp_v_o), 32'(1));
        req_v_i = '1;
        #2;
        nreset = 1'b0;
        #1;
        chk("mid_rst_rsp_v", 32'(rsp_v_o), 32'(0));
        chk("mid_rst_busy", 32'(busy_o), 32'(0));
        chk("mid_rst_rdy", 32'(req_rdy_o), 32'(0));
        chk("mid_rst_add_a", 32'(add_a), 32'(0));
        req_v_i = '0;
        q.delete();
        mptr     = 0;
        last_pop = edge_n;
        @(negedge clk);
        nreset = 1'b1;
        opa[2] = 16'h4049;
        opb[2] = 16'h0F00;
        step(4'b0100, 1'b1);
        chk("post_rst_rdy", 32'(last_rdy), 32'(4'b0100));
        step('0, 1'b1);
        chk("post_rst_rsp_v", 32'(rsp_v_o), 32'(1));
        chk("post_rst_rsp_id", 32'(rsp_id_o), 32'(2));
        chk("post_rst_rsp_data", 32'(rsp_data_o), 32'(16'h4000));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
